// File: rtl/proc_debug_pkg.sv
// ----------------------------------------------------------------------------
// proc_debug_pkg
// Shared constants and types for the processor debug-parameter port. The
// processor's debug mux and the host-side reader both use these so the
// address map stays in one place.
//   DBG_ADDR_W   width of debug_reg_addr
//   DBG_ADDR_IP  address that selects the instruction pointer (r0..r7 are 0..7)
//   dbg_state_t  reader FSM states
//   dbg_addr_step  address sweep helper (increments, saturates at 'last')
// ----------------------------------------------------------------------------
package proc_debug_pkg;

    localparam int DBG_ADDR_W = 4;
    localparam logic [DBG_ADDR_W-1:0] DBG_ADDR_IP = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_STREAM  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RESUME  = 3'd4,
        ST_RELEASE = 3'd5
    } dbg_state_t;

    // Next sweep address: counts up and then parks on the last address.
    function automatic logic [DBG_ADDR_W-1:0] dbg_addr_step(
        input logic [DBG_ADDR_W-1:0] addr,
        input logic [DBG_ADDR_W-1:0] last
    );
        return (addr == last) ? addr : addr + DBG_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/proc_debug_reader_if.sv
// ----------------------------------------------------------------------------
// proc_debug_reader_if
// Snapshot stream channel from the debug reader to a downstream consumer
// (UART/JTAG bridge). Plain valid/ready: a word moves on a rising edge where
// snap_valid && snap_ready.
//   snap_valid  producer has a word
//   snap_ready  consumer accepts the word
//   snap_data   snapshot word
//   snap_index  debug address the word was read from
//   snap_last   marks the final word of a snapshot
// master = producer (reader), slave = consumer.
// ----------------------------------------------------------------------------
interface proc_debug_reader_if
    import proc_debug_pkg::*;
#(
    parameter int WORD_SIZE = 18
);
    logic                  snap_valid;
    logic                  snap_ready;
    logic [WORD_SIZE-1:0]  snap_data;
    logic [DBG_ADDR_W-1:0] snap_index;
    logic                  snap_last;

    modport master (
        output snap_valid,
        output snap_data,
        output snap_index,
        output snap_last,
        input  snap_ready
    );

    modport slave (
        input  snap_valid,
        input  snap_data,
        input  snap_index,
        input  snap_last,
        output snap_ready
    );
endinterface

// File: rtl/debug_snapshot_buf.sv
// ----------------------------------------------------------------------------
// debug_snapshot_buf
// NUM_PARAMS x WORD_SIZE register file holding one halt snapshot.
//   clock    write clock
//   i_wr_en  write strobe
//   i_wr_addr / i_wr_data  write port
//   i_rd_addr  read address (combinational read)
//   o_rd_data  read data; out-of-range addresses read as 0
// Contents are not reset: every entry is rewritten before it is read.
// ----------------------------------------------------------------------------
module debug_snapshot_buf
    import proc_debug_pkg::*;
#(
    parameter int WORD_SIZE  = 18,
    parameter int NUM_PARAMS = 9
)
(
    input  logic                  clock,
    input  logic                  i_wr_en,
    input  logic [DBG_ADDR_W-1:0] i_wr_addr,
    input  logic [WORD_SIZE-1:0]  i_wr_data,
    input  logic [DBG_ADDR_W-1:0] i_rd_addr,
    output logic [WORD_SIZE-1:0]  o_rd_data
);

    logic [WORD_SIZE-1:0] r_mem [NUM_PARAMS];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The reader computes "index+1" one step past the end; return 0 there.
    assign o_rd_data = (int'(i_rd_addr) < NUM_PARAMS) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/proc_debug_reader.sv
// ----------------------------------------------------------------------------
// proc_debug_reader
// Host-side initiator for the processor debug port and wait/continue
// handshake. When the core parks on a wait instruction it sweeps the debug
// address over r0..r7 and ip, captures each word into a snapshot buffer,
// streams the snapshot out, then releases the core with a one-cycle pulse.
//   clock, reset_n            clock, asynchronous active-low reset
//   wait_for_continue         core halted on a wait instruction
//   wait_continue_execution   one-cycle release pulse to the core
//   debug_get_param           debug port enable (high only while capturing)
//   debug_reg_addr            debug parameter address
//   debug_data_out            debug parameter value from the core
//   snap (master)             snapshot stream channel
//   resume_request            consumer permits the core to continue (level)
//   auto_resume               resume without waiting for resume_request
//   busy                      FSM is not idle
//   halt_count                completed halt/resume cycles (wraps)
// All outputs are registered.
// ----------------------------------------------------------------------------
module proc_debug_reader
    import proc_debug_pkg::*;
#(
    parameter int WORD_SIZE     = 18,
    parameter int NUM_PARAMS    = 9,
    parameter int DEBUG_LATENCY = 1
)
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wait_for_continue,
    output logic                  wait_continue_execution,
    output logic                  debug_get_param,
    output logic [DBG_ADDR_W-1:0] debug_reg_addr,
    input  logic [WORD_SIZE-1:0]  debug_data_out,
    proc_debug_reader_if.master   snap,
    input  logic                  resume_request,
    input  logic                  auto_resume,
    output logic                  busy,
    output logic [15:0]           halt_count
);

    localparam int CAP_CYCLES = NUM_PARAMS + DEBUG_LATENCY;
    localparam int CNT_W      = $clog2(CAP_CYCLES + 1);
    localparam logic [DBG_ADDR_W-1:0] LAST_IDX = DBG_ADDR_W'(NUM_PARAMS - 1);

    dbg_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DBG_ADDR_W-1:0] r_addr;
    logic                  r_get_param;
    logic                  r_wce;
    logic                  r_busy;
    logic [15:0]           r_halt_count;
    logic                  r_snap_valid;
    logic [WORD_SIZE-1:0]  r_snap_data;
    logic [DBG_ADDR_W-1:0] r_snap_index;
    logic                  r_snap_last;

    int                    w_wr_off;
    logic                  w_wr_en;
    logic [DBG_ADDR_W-1:0] w_wr_addr;
    logic [DBG_ADDR_W-1:0] w_rd_addr;
    logic [WORD_SIZE-1:0]  w_rd_data;
    logic                  w_xfer;

    // r_cnt counts CAPTURE cycles from 0. The word for address k is on
    // debug_data_out during CAPTURE cycle k+DEBUG_LATENCY-1, so it is written
    // at the end of that cycle.
    assign w_wr_off  = int'(r_cnt) - (DEBUG_LATENCY - 1);
    assign w_wr_en   = (r_state == ST_CAPTURE) && (w_wr_off >= 0) && (w_wr_off < NUM_PARAMS);
    assign w_wr_addr = DBG_ADDR_W'(w_wr_off);

    // Read one word ahead so the next snapshot word loads on the accept edge.
    assign w_rd_addr = (r_state == ST_STREAM) ? r_snap_index + DBG_ADDR_W'(1) : '0;
    assign w_xfer    = r_snap_valid && snap.snap_ready;

    debug_snapshot_buf #(
        .WORD_SIZE  (WORD_SIZE),
        .NUM_PARAMS (NUM_PARAMS)
    ) u_buf (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (debug_data_out),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_get_param  <= 1'b0;
            r_wce        <= 1'b0;
            r_busy       <= 1'b0;
            r_halt_count <= '0;
            r_snap_valid <= 1'b0;
            r_snap_data  <= '0;
            r_snap_index <= '0;
            r_snap_last  <= 1'b0;
        end else begin
            r_wce <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wait_for_continue) begin
                        r_state     <= ST_CAPTURE;
                        r_cnt       <= '0;
                        r_addr      <= '0;
                        r_get_param <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_addr <= dbg_addr_step(r_addr, LAST_IDX);
                    if (r_cnt == CNT_W'(CAP_CYCLES - 1)) begin
                        // Last word is already in the buffer; present word 0.
                        r_state      <= ST_STREAM;
                        r_get_param  <= 1'b0;
                        r_addr       <= '0;
                        r_snap_valid <= 1'b1;
                        r_snap_data  <= w_rd_data;
                        r_snap_index <= '0;
                        r_snap_last  <= (LAST_IDX == '0);
                    end
                end

                ST_STREAM: begin
                    if (w_xfer) begin
                        if (r_snap_last) begin
                            r_state      <= ST_HOLD;
                            r_snap_valid <= 1'b0;
                            r_snap_last  <= 1'b0;
                        end else begin
                            r_snap_index <= r_snap_index + DBG_ADDR_W'(1);
                            r_snap_data  <= w_rd_data;
                            r_snap_last  <= ((r_snap_index + DBG_ADDR_W'(1)) == LAST_IDX);
                        end
                    end
                end

                ST_HOLD: begin
                    if (resume_request || auto_resume) begin
                        r_state      <= ST_RESUME;
                        r_wce        <= 1'b1;
                        r_halt_count <= r_halt_count + 16'd1;
                    end
                end

                ST_RESUME: begin
                    r_state <= ST_RELEASE;
                end

                ST_RELEASE: begin
                    // A still-high wait level belongs to the halt just served.
                    if (!wait_for_continue) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_get_param <= 1'b0;
                end
            endcase
        end
    end

    assign wait_continue_execution = r_wce;
    assign debug_get_param         = r_get_param;
    assign debug_reg_addr          = r_addr;
    assign busy                    = r_busy;
    assign halt_count              = r_halt_count;
    assign snap.snap_valid         = r_snap_valid;
    assign snap.snap_data          = r_snap_data;
    assign snap.snap_index         = r_snap_index;
    assign snap.snap_last          = r_snap_last;

endmodule

// File: tb/tb_proc_debug_reader.sv
// ----------------------------------------------------------------------------
// tb_proc_debug_reader
// Directed bench for proc_debug_reader: one instance at DEBUG_LATENCY=1 with
// a combinational model core, one at DEBUG_LATENCY=3 with a delayed core.
// ----------------------------------------------------------------------------
module tb_proc_debug_reader;
    import proc_debug_pkg::*;

    logic        clk;
    logic        rst_n;

    // Instance 1 (DEBUG_LATENCY = 1)
    logic        wfc, wce, get_param, resume_req, auto_res, busy;
    logic [3:0]  dbg_addr;
    logic [17:0] dbg_data;
    logic [15:0] hcount;
    logic [17:0] core_regs [9];
    logic [17:0] exp_tab   [9];

    // Instance 2 (DEBUG_LATENCY = 3)
    logic        wfc2, wce2, get_param2, busy2;
    logic [3:0]  dbg_addr2, addr2_d1, addr2_d2;
    logic [17:0] dbg_data2;
    logic [15:0] hcount2;
    logic [17:0] core_regs2 [9];
    logic [17:0] exp_tab2   [9];

    int n_checks = 0;
    int n_errors = 0;

    // Observation results for one halt.
    int          n_xfer, first_valid_t, pulse_t, n_pulse, cap_cycles;
    logic        prev_stall;
    logic [17:0] prev_data;
    logic [3:0]  prev_index;
    logic        prev_last;

    proc_debug_reader_if #(.WORD_SIZE(18)) snap_if  ();
    proc_debug_reader_if #(.WORD_SIZE(18)) snap_if2 ();

    proc_debug_reader #(.WORD_SIZE(18), .NUM_PARAMS(9), .DEBUG_LATENCY(1)) dut (
        .clock                   (clk),
        .reset_n                 (rst_n),
        .wait_for_continue       (wfc),
        .wait_continue_execution (wce),
        .debug_get_param         (get_param),
        .debug_reg_addr          (dbg_addr),
        .debug_data_out          (dbg_data),
        .snap                    (snap_if),
        .resume_request          (resume_req),
        .auto_resume             (auto_res),
        .busy                    (busy),
        .halt_count              (hcount)
    );

    proc_debug_reader #(.WORD_SIZE(18), .NUM_PARAMS(9), .DEBUG_LATENCY(3)) dut2 (
        .clock                   (clk),
        .reset_n                 (rst_n),
        .wait_for_continue       (wfc2),
        .wait_continue_execution (wce2),
        .debug_get_param         (get_param2),
        .debug_reg_addr          (dbg_addr2),
        .debug_data_out          (dbg_data2),
        .snap                    (snap_if2),
        .resume_request          (1'b0),
        .auto_resume             (1'b1),
        .busy                    (busy2),
        .halt_count              (hcount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model core, latency 1: data follows the address within the same cycle.
    assign dbg_data = (dbg_addr < 4'd9) ? core_regs[dbg_addr] : 18'h0;

    // Model core, latency 3: two address registers before the lookup.
    always_ff @(posedge clk) begin
        addr2_d1 <= dbg_addr2;
        addr2_d2 <= addr2_d1;
    end
    assign dbg_data2 = (addr2_d2 < 4'd9) ? core_regs2[addr2_d2] : 18'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Watch instance 1 for ncyc cycles; t=0 is the first negedge after the
    // edge that sampled wait_for_continue high. mode 1 drives ready 1,0,0,...
    task automatic observe(input int ncyc, input int mode);
        n_xfer = 0; first_valid_t = -1; pulse_t = -1; n_pulse = 0;
        cap_cycles = 0; prev_stall = 1'b0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (get_param) begin
                cap_cycles++;
                check("cap_addr", dbg_addr, (t < 8) ? t : 8);
            end
            if (snap_if.snap_valid && first_valid_t < 0) first_valid_t = t;
            if (wce) begin
                n_pulse++;
                pulse_t = t;
            end
            if (prev_stall) begin
                check("stall_data",  snap_if.snap_data,  prev_data);
                check("stall_index", snap_if.snap_index, prev_index);
                check("stall_last",  snap_if.snap_last,  prev_last);
            end
            snap_if.snap_ready = (mode == 1) ? ((t % 3) == 0) : 1'b1;
            if (snap_if.snap_valid && snap_if.snap_ready) begin
                if (n_xfer < 9) begin
                    check("xfer_index", snap_if.snap_index, n_xfer);
                    check("xfer_data",  snap_if.snap_data,  exp_tab[n_xfer]);
                    check("xfer_last",  snap_if.snap_last,  (n_xfer == int'(DBG_ADDR_IP)));
                end
                n_xfer++;
            end
            prev_stall = snap_if.snap_valid && !snap_if.snap_ready;
            prev_data  = snap_if.snap_data;
            prev_index = snap_if.snap_index;
            prev_last  = snap_if.snap_last;
        end
        snap_if.snap_ready = 1'b1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        wfc = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int n2, cap2, pulse2_t, np2, resets_pulses;
        core_regs  = '{18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h00005,
                       18'h00006, 18'h00007, 18'h00008, 18'h0003F};
        exp_tab    = '{18'h00001, 18'h00002, 18'h00003, 18'h00004, 18'h00005,
                       18'h00006, 18'h00007, 18'h00008, 18'h0003F};
        core_regs2 = '{18'h3FFFF, 18'h2AAAA, 18'h15555, 18'h00100, 18'h12345,
                       18'h0ABCD, 18'h30000, 18'h00001, 18'h1FFFF};
        exp_tab2   = '{18'h3FFFF, 18'h2AAAA, 18'h15555, 18'h00100, 18'h12345,
                       18'h0ABCD, 18'h30000, 18'h00001, 18'h1FFFF};
        rst_n = 1'b0; wfc = 1'b0; wfc2 = 1'b0;
        resume_req = 1'b0; auto_res = 1'b1;
        snap_if.snap_ready  = 1'b1;
        snap_if2.snap_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",   busy,               1'b0);
        check("rst_wce",    wce,                1'b0);
        check("rst_get",    get_param,          1'b0);
        check("rst_addr",   dbg_addr,           4'd0);
        check("rst_valid",  snap_if.snap_valid, 1'b0);
        check("rst_hcount", hcount,             16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy0", busy, 1'b0);

        // Latency-3 instance: 12 capture cycles, pulse at (9+3)+9+1 = 22
        wfc2 = 1'b1;
        n2 = 0; cap2 = 0; pulse2_t = -1; np2 = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (get_param2) cap2++;
            if (wce2) begin
                np2++;
                pulse2_t = t;
            end
            if (snap_if2.snap_valid) begin
                if (n2 < 9) begin
                    check("l3_index", snap_if2.snap_index, n2);
                    check("l3_data",  snap_if2.snap_data,  exp_tab2[n2]);
                end
                n2++;
            end
        end
        wfc2 = 1'b0;
        check("l3_cap_cycles", cap2, 12);
        check("l3_n_xfer",     n2, 9);
        check("l3_pulse_t",    pulse2_t, 22);
        check("l3_n_pulse",    np2, 1);
        check("l3_hcount",     hcount2, 16'd1);

        // Halt 1: auto resume, ready always high
        wfc = 1'b1;
        observe(25, 0);
        check("h1_cap_cycles", cap_cycles, 10);
        check("h1_first_valid", first_valid_t, 10);
        check("h1_n_xfer", n_xfer, 9);
        check("h1_pulse_t", pulse_t, 20);
        check("h1_n_pulse", n_pulse, 1);
        check("h1_hcount", hcount, 16'd1);
        go_idle();

        // Halt 2: ready 1,0,0 pattern; last accept at t=36, pulse at t=38
        wfc = 1'b1;
        observe(45, 1);
        check("h2_n_xfer", n_xfer, 9);
        check("h2_pulse_t", pulse_t, 38);
        check("h2_n_pulse", n_pulse, 1);
        check("h2_hcount", hcount, 16'd2);
        go_idle();

        // Halt 3: manual resume, held off 50 cycles after the stream
        auto_res = 1'b0;
        wfc = 1'b1;
        observe(69, 0);
        check("h3_n_xfer", n_xfer, 9);
        check("h3_no_pulse", n_pulse, 0);
        check("h3_busy", busy, 1'b1);
        resume_req = 1'b1;
        @(negedge clk);
        check("h3_pulse", wce, 1'b1);
        resume_req = 1'b0;
        auto_res = 1'b1;
        @(negedge clk);
        check("h3_pulse_width", wce, 1'b0);
        check("h3_hcount", hcount, 16'd3);

        // wait_for_continue stays high 100 cycles: no recapture
        observe(100, 0);
        check("hold_cap", cap_cycles, 0);
        check("hold_xfer", n_xfer, 0);
        check("hold_pulse", n_pulse, 0);
        check("hold_busy", busy, 1'b1);
        go_idle();

        // Re-raise: a second snapshot of this pair of halts
        wfc = 1'b1;
        observe(25, 0);
        check("h4_n_xfer", n_xfer, 9);
        check("h4_pulse_t", pulse_t, 20);
        check("h4_hcount", hcount, 16'd4);
        go_idle();

        // Reset while word 4 is presented
        wfc = 1'b1;
        for (int t = 0; t < 15; t++) @(negedge clk);
        check("mid_valid", snap_if.snap_valid, 1'b1);
        check("mid_index", snap_if.snap_index, 4'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",  snap_if.snap_valid, 1'b0);
        check("arst_data",   snap_if.snap_data,  18'h0);
        check("arst_index",  snap_if.snap_index, 4'd0);
        check("arst_busy",   busy,               1'b0);
        check("arst_hcount", hcount,             16'd0);
        resets_pulses = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (wce) resets_pulses++;
        end
        check("arst_no_pulse", resets_pulses, 0);
        rst_n = 1'b1;
        observe(25, 0);
        check("post_cap_cycles", cap_cycles, 10);
        check("post_n_xfer", n_xfer, 9);
        check("post_pulse_t", pulse_t, 20);
        check("post_hcount", hcount, 16'd1);
        go_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/proc_debug_reader.md
# proc_debug_reader

Host-side initiator for the processor's debug-parameter interface and wait/continue handshake. When the core parks on a wait instruction (`wait_for_continue` high), this block sweeps `debug_reg_addr` over r0..r7 and ip and captures each word into a 9-entry snapshot buffer. It then streams the snapshot to a downstream consumer (UART/JTAG bridge) over a valid/ready channel and releases the core with a one-cycle `wait_continue_execution` pulse. It sits beside `processor` / `processor_staged` at the top level, in place of the testbench-driven debug signals.

## Interface
- `WORD_SIZE`, 18, processor word width.
- `NUM_PARAMS`, 9, debug parameters read per halt (addresses 0..NUM_PARAMS-1; 0..7 = r0..r7, 8 = ip).
- `DEBUG_LATENCY`, 1, cycles from `debug_reg_addr` change to valid `debug_data_out` (1..3).
- `clock` in 1, single clock, all logic on rising edge.
- `reset_n` in 1, asynchronous active-low reset.
- `wait_for_continue` in 1, core is halted on a wait instruction.
- `wait_continue_execution` out 1, one-cycle release pulse to the core.
- `debug_get_param` out 1, debug port enable; high only while capturing.
- `debug_reg_addr` out 4, parameter address.
- `debug_data_out` in WORD_SIZE, parameter value from the core.
- `snap_valid` out 1, snapshot word available.
- `snap_ready` in 1, consumer accepts word.
- `snap_data` out WORD_SIZE, snapshot word.
- `snap_index` out 4, parameter address of `snap_data`.
- `snap_last` out 1, high with index NUM_PARAMS-1.
- `resume_request` in 1, level; consumer permits the core to continue.
- `auto_resume` in 1, level; skip waiting for `resume_request`.
- `busy` out 1, state != IDLE.
- `halt_count` out 16, number of completed halt/resume cycles, wraps at 65535→0.

## Operation
- States: IDLE, CAPTURE, STREAM, HOLD, RESUME, RELEASE.
- IDLE: on `wait_for_continue`=1, go to CAPTURE, clear the address counter.
- CAPTURE: pipelined sweep. `debug_get_param`=1. `debug_reg_addr` = 0,1,…,NUM_PARAMS-1 on consecutive cycles, then holds NUM_PARAMS-1. The word for address k is written to `buf[k]` on the edge DEBUG_LATENCY cycles after address k was driven. After the last write, go to STREAM and drop `debug_get_param`.
- STREAM: present `buf[i]` for i=0..NUM_PARAMS-1. A transfer occurs on an edge where `snap_valid`&&`snap_ready`. `snap_data`, `snap_index` and `snap_last` hold stable while `snap_valid`=1 and not accepted. After the transfer with `snap_last`, go to HOLD.
- HOLD: if `resume_request`||`auto_resume`, go to RESUME.
- RESUME: `wait_continue_execution`=1 for exactly this one cycle. `halt_count` increments. Next state is RELEASE.
- RELEASE: wait for `wait_for_continue`=0, then go to IDLE. This prevents a second capture of the same halt. A new halt is captured only after a low level has been seen.
- If `wait_for_continue` drops during CAPTURE, STREAM or HOLD, the current sequence still completes, including the resume pulse. Spurious releases are harmless to the core.
- Unused `debug_reg_addr` bits are 0.

## Timing
- Reset (async, `reset_n`=0): state IDLE; all outputs 0; `halt_count`=0; buffer contents don't-care. Reset mid-operation aborts immediately with no resume pulse.
- CAPTURE lasts NUM_PARAMS+DEBUG_LATENCY cycles.
- The first `snap_valid` appears the cycle after CAPTURE exits.
- Streaming throughput is 1 word/cycle with `snap_ready` held high.
- With `auto_resume`=1 and `snap_ready`=1 throughout, the resume pulse comes (NUM_PARAMS+DEBUG_LATENCY)+NUM_PARAMS+1 cycles after `wait_for_continue` is sampled high. This is 20 cycles at the defaults.
- The `wait_continue_execution` pulse width is always exactly 1 cycle.
- All outputs are registered.

## Structure
- Shared package `proc_debug_pkg`: state enum `dbg_state_t`, `DBG_ADDR_IP` = 4'd8, `DBG_ADDR_W` = 4. The processor debug mux uses the same constants.
- Sub-module `debug_snapshot_buf`: NUM_PARAMS×WORD_SIZE register file with one write port and one read port. All other logic is in the top FSM.

## Test plan
- Halt with r0..r7 = 18'h00001..18'h00008 and ip = 18'h0003F; `auto_resume`=1, `snap_ready`=1 → nine transfers in consecutive cycles, in index order 0..8, with those values. `snap_last` is high only on index 8. One resume pulse arrives 20 cycles after the halt, and `halt_count` becomes 1.
- Same halt with `snap_ready` toggled 1,0,0,1,… → no word is lost or duplicated, and data stays stable while stalled.
- `auto_resume`=0 with `resume_request` held low for 50 cycles after the stream → no pulse and `busy`=1. Raising `resume_request` → pulse on the next cycle.
- `wait_for_continue` held high for 100 cycles after the resume → exactly one capture and one pulse. Drop it, then re-raise → a second snapshot, and `halt_count`=2.
- DEBUG_LATENCY=3 with a model core that delays data by 3 cycles → the buffer matches, and CAPTURE lasts 12 cycles.
- Assert `reset_n`=0 during STREAM at word 4 → outputs 0 asynchronously, no resume pulse, and `halt_count`=0. After release with `wait_for_continue` still high, a fresh capture starts.
